// File: rtl/uart_fifo_if.sv
// uart_fifo_if: buffered host front end for the RS-232 UART (TX and RX FIFOs plus UART req/ack handshakes)
// Ports: clk, reset (sync, active-high)
//   host : wr_en/wr_data push TX; rd_en pops RX; rd_data/rx_valid show-ahead RX head;
//          tx_full, tx_count, rx_count status; sticky tx_ovf/rx_udf cleared by clr_err
//   UART : ld_tx_req/ld_tx_ack/tx_data load a byte; rx_req/rx_ack/uart_rx_data/uart_rx_empty unload a byte
module uart_fifo_if #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rx_valid,
    output logic          tx_full,
    output logic [AW:0]   tx_count,
    output logic [AW:0]   rx_count,
    output logic          tx_ovf,
    output logic          rx_udf,
    input  logic          clr_err,
    output logic          ld_tx_req,
    input  logic          ld_tx_ack,
    output logic [7:0]    tx_data,
    output logic          rx_req,
    input  logic          rx_ack,
    input  logic [7:0]    uart_rx_data,
    input  logic          uart_rx_empty
);
    localparam int CW = AW + 1;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    typedef enum logic [1:0] {TI, TREQ, TWAIT} tx_st_t;
    typedef enum logic [1:0] {RI, RREQ, RWAIT} rx_st_t;
    logic [7:0] tx_mem [2**AW];
    logic [7:0] rx_mem [2**AW];
    logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [AW:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
    logic ld_tx_req_q, rx_req_q;
    logic tx_push, tx_pop, rx_push, rx_pop;
    tx_st_t tx_st_q;
    rx_st_t rx_st_q;
    assign tx_full   = tx_cnt_q == DEPTH;
    assign rx_valid  = rx_cnt_q != '0;
    assign tx_count  = tx_cnt_q;
    assign rx_count  = rx_cnt_q;
    assign tx_ovf    = tx_ovf_q;
    assign rx_udf    = rx_udf_q;
    assign ld_tx_req = ld_tx_req_q;
    assign rx_req    = rx_req_q;
    assign tx_data   = tx_cnt_q != '0 ? tx_mem[tx_rp_q] : '0;
    assign rd_data   = rx_valid ? rx_mem[rx_rp_q] : '0;
    always_comb begin
        tx_push  = wr_en && !tx_full;
        tx_pop   = tx_st_q == TREQ && ld_tx_ack;
        rx_push  = rx_st_q == RREQ && rx_ack;
        rx_pop   = rd_en && rx_valid;
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        // a fresh error event wins over a same-cycle clear
        tx_ovf_d = (wr_en && tx_full) || (tx_ovf_q && !clr_err);
        rx_udf_d = (rd_en && !rx_valid) || (rx_udf_q && !clr_err);
    end
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= wr_data;
        if (rx_push) rx_mem[rx_wp_q] <= uart_rx_data;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
            rx_udf_q <= 1'b0;
        end else begin
            tx_wp_q  <= tx_wp_q + AW'(tx_push);
            tx_rp_q  <= tx_rp_q + AW'(tx_pop);
            rx_wp_q  <= rx_wp_q + AW'(rx_push);
            rx_rp_q  <= rx_rp_q + AW'(rx_pop);
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            tx_ovf_q <= tx_ovf_d;
            rx_udf_q <= rx_udf_d;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_st_q     <= TI;
            ld_tx_req_q <= 1'b0;
        end else begin
            case (tx_st_q)
                TI:      if (tx_cnt_q != '0) begin
                             tx_st_q     <= TREQ;
                             ld_tx_req_q <= 1'b1;
                         end
                TREQ:    if (ld_tx_ack) begin
                             tx_st_q     <= TWAIT;
                             ld_tx_req_q <= 1'b0;
                         end
                TWAIT:   if (!ld_tx_ack) tx_st_q <= TI;
                default: tx_st_q <= TI;
            endcase
        end
    end
    // the full check in RI guarantees rx_push never lands on a full FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_st_q  <= RI;
            rx_req_q <= 1'b0;
        end else begin
            case (rx_st_q)
                RI:      if (!uart_rx_empty && rx_cnt_q != DEPTH) begin
                             rx_st_q  <= RREQ;
                             rx_req_q <= 1'b1;
                         end
                RREQ:    if (rx_ack) begin
                             rx_st_q  <= RWAIT;
                             rx_req_q <= 1'b0;
                         end
                RWAIT:   if (!rx_ack) rx_st_q <= RI;
                default: rx_st_q <= RI;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_fifo_if.sv
// tb_uart_fifo_if: scoreboard bench for uart_fifo_if with behavioural UART load/unload models
module tb_uart_fifo_if;
    logic clk = 0, reset = 1, wr_en = 0, rd_en = 0, clr_err = 0;
    logic [7:0] wr_data = 0;
    logic ld_tx_ack = 0, rx_ack = 0, uart_rx_empty = 1;
    logic [7:0] uart_rx_data = 0;
    logic [7:0] rd_data, tx_data;
    logic rx_valid, tx_full, tx_ovf, rx_udf, ld_tx_req, rx_req;
    logic [4:0] tx_count, rx_count;
    int checks = 0, errors = 0;
    bit tx_auto = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] src[$];

    uart_fifo_if dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rx_valid(rx_valid), .tx_full(tx_full), .tx_count(tx_count),
        .rx_count(rx_count), .tx_ovf(tx_ovf), .rx_udf(rx_udf), .clr_err(clr_err),
        .ld_tx_req(ld_tx_req), .ld_tx_ack(ld_tx_ack), .tx_data(tx_data), .rx_req(rx_req),
        .rx_ack(rx_ack), .uart_rx_data(uart_rx_data), .uart_rx_empty(uart_rx_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic host_wr(input logic [7:0] d, input bit acc);
        wr_en = 1;
        wr_data = d;
        if (acc) exp_tx.push_back(d);
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic wait_tx_idle(input string name, input int n);
        bit ok = 0;
        for (int i = 0; i < n && !ok; i++) begin
            @(negedge clk);
            ok = tx_count == 0 && !ld_tx_req && !ld_tx_ack;
        end
        chk(name, ok, 1);
    endtask

    // UART load side: ack each request and score the byte it takes
    always @(negedge clk) begin
        #1;
        if (reset) ld_tx_ack = 0;
        else if (tx_auto) begin
            if (ld_tx_req && !ld_tx_ack) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got %0h expected none", tx_data);
                end else chk("tx_data", tx_data, exp_tx.pop_front());
                ld_tx_ack = 1;
            end else if (!ld_tx_req && ld_tx_ack) ld_tx_ack = 0;
        end
    end

    // UART unload side: present src head, ack requests, record what the DUT will store
    always @(negedge clk) begin
        #1;
        if (reset) rx_ack = 0;
        else if (!rx_ack && rx_req) begin
            chk("rx_req_nonempty", uart_rx_empty, 0);
            rx_ack = 1;
            exp_rx.push_back(uart_rx_data);
        end else if (rx_ack && !rx_req) begin
            rx_ack = 0;
            void'(src.pop_front());
        end
        if (!rx_ack) begin
            uart_rx_empty = src.size() == 0;
            uart_rx_data = uart_rx_empty ? 8'h00 : src[0];
        end
    end

    // host read monitor
    always @(negedge clk) begin
        #1;
        if (!reset && rd_en && rx_valid) begin
            if (exp_rx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %0h expected none", rd_data);
            end else chk("rx_data", rd_data, exp_rx.pop_front());
        end
    end

    initial begin
        bit ok;
        repeat (2) @(negedge clk);
        chk("rst_ld_tx_req", ld_tx_req, 0);
        chk("rst_rx_req", rx_req, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_tx_count", tx_count, 0);
        chk("rst_rx_count", rx_count, 0);
        chk("rst_tx_ovf", tx_ovf, 0);
        chk("rst_rx_udf", rx_udf, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rd_data", rd_data, 0);
        reset = 0;
        @(negedge clk);

        tx_auto = 1;
        host_wr(8'h55, 1);
        chk("t1_req_cycle1", ld_tx_req, 0);
        @(negedge clk);
        chk("t1_req_cycle2", ld_tx_req, 1);
        chk("t1_tx_data", tx_data, 8'h55);
        wait_tx_idle("t1_idle", 50);
        chk("t1_tx_count", tx_count, 0);
        chk("t1_all_sent", exp_tx.size(), 0);

        tx_auto = 0;
        for (int i = 0; i < 16; i++) host_wr(8'(i), 1);
        chk("t2_full", tx_full, 1);
        chk("t2_count", tx_count, 16);
        chk("t2_ovf_before", tx_ovf, 0);
        host_wr(8'hAA, 0);
        chk("t2_ovf", tx_ovf, 1);
        chk("t2_count_after", tx_count, 16);
        clr_err = 1;
        @(negedge clk);
        clr_err = 0;
        chk("t2_ovf_clr", tx_ovf, 0);
        clr_err = 1;
        host_wr(8'hAB, 0);
        clr_err = 0;
        chk("t2_ovf_wins_clr", tx_ovf, 1);
        tx_auto = 1;
        wait_tx_idle("t2_idle", 300);
        chk("t2_all_sent", exp_tx.size(), 0);
        chk("t2_not_full", tx_full, 0);

        src.push_back(8'h3C);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = rx_valid;
        end
        chk("t3_rx_valid", rx_valid, 1);
        chk("t3_rd_data", rd_data, 8'h3C);
        chk("t3_rx_count", rx_count, 1);
        rd_en = 1;
        @(negedge clk);
        rd_en = 0;
        chk("t3_rx_valid_after", rx_valid, 0);
        chk("t3_rx_count_after", rx_count, 0);

        for (int i = 0; i < 17; i++) src.push_back(8'hA0 + 8'(i));
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = rx_count == 16;
        end
        repeat (10) @(negedge clk);
        chk("t4_rx_count_full", rx_count, 16);
        chk("t4_rx_req_held", rx_req, 0);
        chk("t4_uart_kept", src.size(), 1);
        chk("t4_exp_depth", exp_rx.size(), 16);
        rd_en = 1;
        @(negedge clk);
        rd_en = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = rx_count == 16 && !rx_ack;
        end
        chk("t4_refill", rx_count, 16);
        chk("t4_uart_drained", src.size(), 0);
        for (int i = 0; i < 40 && rx_valid; i++) begin
            rd_en = 1;
            @(negedge clk);
        end
        rd_en = 0;
        chk("t4_empty", rx_valid, 0);
        chk("t4_all_read", exp_rx.size(), 0);

        rd_en = 1;
        @(negedge clk);
        rd_en = 0;
        chk("t5_udf", rx_udf, 1);
        clr_err = 1;
        @(negedge clk);
        clr_err = 0;
        chk("t5_udf_clr", rx_udf, 0);

        tx_auto = 0;
        host_wr(8'h77, 0);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = ld_tx_req;
        end
        chk("t6_req_up", ld_tx_req, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("t6_req_drop", ld_tx_req, 0);
        chk("t6_tx_count", tx_count, 0);
        chk("t6_tx_data", tx_data, 0);
        tx_auto = 1;
        repeat (20) @(negedge clk);
        chk("t6_no_req", ld_tx_req, 0);
        chk("t6_nothing_pending", exp_tx.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
